// File: rtl/usb3_slfifo_wr.sv
// usb3_slfifo_wr
// FPGA->host write path for the FX3 GPIF-II slave-FIFO link.
// Words are taken from a source FIFO over valid/ready and written to the FX3
// in fixed bursts of BURST_LEN words. A burst starts only once FLAGB shows
// that the FX3 has room for a whole burst.
//
// Handshake: a word moves when src_valid && src_ready are both high at a
// rising clk edge. src_ready depends only on state and the burst counter,
// never on src_valid. Each accepted word gives exactly one SLWR_N low cycle,
// with that word on DQ, in the cycle after the transfer.
//
// Ports
//   clk, rst        FX3 PCLK domain clock; synchronous active-high reset
//   src_data/valid  word and valid flag from the source FIFO
//   src_ready       block accepts src_data this cycle
//   USB3_FLAGB      1 = FX3 has room for a full burst
//   USB3_SLWR_N     registered write strobe, active low
//   USB3_PKTEND_N   registered packet-end strobe, active low
//   USB3_DQ_OUT     registered data to the DQ pads
//   USB3_DQ_OE      1 = FPGA drives DQ (every state except IDLE)
//   usb_wr_state    current state code, for debug
//   words_sent      running count of words written, wraps at 2^32
//
// Build option: define USB3_WR_PKTEND_EN to commit a short packet (PKTEND)
// after PKT_TIMEOUT idle cycles in a partly filled burst. Without it,
// PKTEND_N stays high and only full bursts are sent.
module usb3_slfifo_wr #(
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_LEN   = 256,
   parameter int FLAG_DELAY  = 3,
   parameter int PKT_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] src_data,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic                  USB3_FLAGB,
   output logic                  USB3_SLWR_N,
   output logic                  USB3_PKTEND_N,
   output logic [DATA_WIDTH-1:0] USB3_DQ_OUT,
   output logic                  USB3_DQ_OE,
   output logic [3:0]            usb_wr_state,
   output logic [31:0]           words_sent
);

   localparam int CW = $clog2(BURST_LEN) + 1;
   localparam int GW = $clog2(FLAG_DELAY + 1);
   localparam logic [CW-1:0] BURST_MAX  = CW'(BURST_LEN);
   localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
   localparam logic [GW-1:0] GUARD_LAST = GW'(FLAG_DELAY - 1);

   if (BURST_LEN < 2) begin : g_bad_burst_len
      $error("usb3_slfifo_wr: BURST_LEN must be at least 2");
   end
   if (FLAG_DELAY < 1) begin : g_bad_flag_delay
      $error("usb3_slfifo_wr: FLAG_DELAY must be at least 1");
   end
   if (PKT_TIMEOUT < 1) begin : g_bad_pkt_timeout
      $error("usb3_slfifo_wr: PKT_TIMEOUT must be at least 1");
   end

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_WAIT_FLAG = 4'd1,
      ST_WR_BURST  = 4'd2,
      ST_GUARD     = 4'd3,
      ST_PKTEND    = 4'd4
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] burst_cnt;
   logic [GW-1:0] guard_cnt;
   logic          xfer;
   logic          timeout_hit;

   assign src_ready    = (state == ST_WR_BURST) && (burst_cnt < BURST_MAX);
   assign xfer         = src_valid && src_ready;
   assign USB3_DQ_OE   = (state != ST_IDLE);
   assign usb_wr_state = state;

`ifdef USB3_WR_PKTEND_EN
   localparam int IW = $clog2(PKT_TIMEOUT + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(PKT_TIMEOUT - 1);

   logic [IW-1:0] idle_cnt;
   logic          pktend_n;

   // An empty burst (counter 0) never times out, so no zero-length packet.
   assign timeout_hit = (state == ST_WR_BURST) && !xfer &&
                        (burst_cnt != '0) && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
         pktend_n <= 1'b1;
      end else begin
         // Registered from next state so the strobe lines up with PKTEND.
         pktend_n <= (state_next != ST_PKTEND);
         if ((state != ST_WR_BURST) || xfer || (burst_cnt == '0))
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign USB3_PKTEND_N = pktend_n;
`else
   assign timeout_hit   = 1'b0;
   assign USB3_PKTEND_N = 1'b1;
`endif

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:      if (src_valid)  state_next = ST_WAIT_FLAG;
         ST_WAIT_FLAG: if (USB3_FLAGB) state_next = ST_WR_BURST;
         ST_WR_BURST: begin
            if (xfer && (burst_cnt == BURST_LAST))
               state_next = ST_GUARD;
            else if (timeout_hit)
               state_next = ST_PKTEND;
         end
         // FLAGB is stale for FLAG_DELAY cycles after the last strobe.
         ST_GUARD:     if (guard_cnt == GUARD_LAST) state_next = ST_IDLE;
         ST_PKTEND:    state_next = ST_GUARD;
         default:      state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         burst_cnt   <= '0;
         guard_cnt   <= '0;
         USB3_SLWR_N <= 1'b1;
         USB3_DQ_OUT <= '0;
         words_sent  <= '0;
      end else begin
         state       <= state_next;
         USB3_SLWR_N <= !xfer;
         if (xfer) begin
            USB3_DQ_OUT <= src_data;
            words_sent  <= words_sent + 32'd1;
         end
         // Cleared while waiting, so every burst starts from zero.
         if (state == ST_WAIT_FLAG)
            burst_cnt <= '0;
         else if (xfer)
            burst_cnt <= burst_cnt + 1'b1;
         if (state == ST_GUARD)
            guard_cnt <= guard_cnt + 1'b1;
         else
            guard_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_usb3_slfifo_wr.sv
// Testbench for usb3_slfifo_wr with default parameters. Every cycle the DUT
// outputs are compared against a behavioural model of the burst rules. A
// vector table covers reset and the start of a burst. Hand-written sequences
// cover the multi-cycle cases, and randomized traffic runs at the end.
module tb_usb3_slfifo_wr;

   localparam int BL = 256;
   localparam int FD = 3;
   localparam int PT = 64;
`ifdef USB3_WR_PKTEND_EN
   localparam bit PKTEND_ON = 1'b1;
`else
   localparam bit PKTEND_ON = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk;
   logic        rst;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic        flagb;
   logic        slwr_n;
   logic        pktend_n;
   logic [31:0] dq_out;
   logic        dq_oe;
   logic [3:0]  usb_wr_state;
   logic [31:0] words_sent;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   usb3_slfifo_wr dut (
      .clk           (clk),
      .rst           (rst),
      .src_data      (src_data),
      .src_valid     (src_valid),
      .src_ready     (src_ready),
      .USB3_FLAGB    (flagb),
      .USB3_SLWR_N   (slwr_n),
      .USB3_PKTEND_N (pktend_n),
      .USB3_DQ_OUT   (dq_out),
      .USB3_DQ_OE    (dq_oe),
      .usb_wr_state  (usb_wr_state),
      .words_sent    (words_sent)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bookkeeping ----------------
   int n_vec  = 0;
   int n_miss = 0;
   int pulse_cnt  = 0;
   int pktend_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phase codes follow the published state codes; the burst is tracked as
   // the number of words still allowed, the guard as cycles remaining.
   int          m_state;
   int          m_room;
   int          m_wait;
   int          m_quiet;
   logic [31:0] m_sent;
   logic        m_slwr_n;
   logic        m_pktend_n;
   logic [31:0] m_dq;
   logic [31:0] exp_q[$];

   function automatic bit m_ready();
      return (m_state == 2) && (m_room > 0);
   endfunction

   task automatic model_reset();
      m_state = 0; m_room = 0; m_wait = 0; m_quiet = 0;
      m_sent = 0; m_slwr_n = 1'b1; m_pktend_n = 1'b1; m_dq = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit take;
      take       = src_valid && m_ready();
      m_slwr_n   = !take;
      m_pktend_n = 1'b1;
      if (take) begin
         exp_q.push_back(src_data);
         m_dq   = src_data;
         m_sent = m_sent + 1;
      end
      case (m_state)
         0: if (src_valid) m_state = 1;
         1: if (flagb) begin m_state = 2; m_room = BL; m_quiet = 0; end
         2: begin
            if (take) begin
               m_room  = m_room - 1;
               m_quiet = 0;
               if (m_room == 0) begin m_state = 3; m_wait = FD; end
            end else if (PKTEND_ON && (m_room < BL)) begin
               m_quiet = m_quiet + 1;
               if (m_quiet == PT) begin m_state = 4; m_pktend_n = 1'b0; end
            end
         end
         3: begin
            m_wait = m_wait - 1;
            if (m_wait == 0) m_state = 0;
         end
         default: begin m_state = 3; m_wait = FD; end
      endcase
   endtask

   // ---------------- per-cycle compare / scoreboard ----------------
   task automatic compare_all();
      logic [31:0] sb_exp;
      check("state",      usb_wr_state, 4'(m_state));
      check("slwr_n",     slwr_n,       m_slwr_n);
      check("pktend_n",   pktend_n,     m_pktend_n);
      check("dq_oe",      dq_oe,        m_state != 0);
      check("src_ready",  src_ready,    m_ready());
      check("words_sent", words_sent,   m_sent);
      check("dq_out",     dq_out,       m_dq);
      if (slwr_n === 1'b0) begin
         pulse_cnt++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_extra: write strobe with no word pending at %0t", $time);
         end else begin
            sb_exp = exp_q.pop_front();
            check("sb_word", dq_out, sb_exp);
         end
      end
      if (pktend_n === 1'b0) pktend_cnt++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      if (rst) model_reset();
      else     model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1; src_valid = 1'b0; flagb = 1'b0; src_data = '0;
      cycle();
      cycle();
      rst = 1'b0;
      pulse_cnt = 0;
      pktend_cnt = 0;
   endtask

   // Feeds words until the model is back in IDLE after a guard period.
   task automatic run_until_idle(input string name, input int max_cyc);
      bit done;
      done = 1'b0;
      flagb = 1'b1;
      for (int i = 0; i < max_cyc && !done; i++) begin
         src_valid = ($urandom_range(0, 3) != 0);
         src_data  = $urandom();
         cycle();
         if (m_state == 0) done = 1'b1;
      end
      src_valid = 1'b0;
      check(name, done, 1'b1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst;
      logic        valid;
      logic        flagb;
      logic [31:0] data;
      logic [3:0]  e_state;
      logic        e_slwr_n;
      logic        e_ready;
      logic [31:0] e_dq;
      logic [31:0] e_ws;
   } vec_t;

   vec_t vec[10];

   initial begin
      int          pulses, run, max_run, guard_cycles, bad, pk, pk_at;
      logic [31:0] nxt, seq_exp;
      bit          done, take;

      model_reset();
      rst = 1'b1; src_valid = 1'b0; flagb = 1'b0; src_data = '0;

      //            rst   valid flagb data        st    slwr  rdy   dq          ws
      vec[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  4'd0, 1'b1, 1'b0, 32'h0,  32'd0};
      vec[1] = '{1'b1, 1'b1, 1'b1, 32'h9,  4'd0, 1'b1, 1'b0, 32'h0,  32'd0};
      vec[2] = '{1'b0, 1'b1, 1'b0, 32'h1,  4'd1, 1'b1, 1'b0, 32'h0,  32'd0};
      vec[3] = '{1'b0, 1'b1, 1'b0, 32'h2,  4'd1, 1'b1, 1'b0, 32'h0,  32'd0};
      vec[4] = '{1'b0, 1'b1, 1'b1, 32'h5,  4'd2, 1'b1, 1'b1, 32'h0,  32'd0};
      vec[5] = '{1'b0, 1'b1, 1'b1, 32'h11, 4'd2, 1'b0, 1'b1, 32'h11, 32'd1};
      vec[6] = '{1'b0, 1'b0, 1'b1, 32'h22, 4'd2, 1'b1, 1'b1, 32'h11, 32'd1};
      vec[7] = '{1'b0, 1'b1, 1'b1, 32'h33, 4'd2, 1'b0, 1'b1, 32'h33, 32'd2};
      vec[8] = '{1'b0, 1'b1, 1'b0, 32'h44, 4'd2, 1'b0, 1'b1, 32'h44, 32'd3};
      vec[9] = '{1'b0, 1'b0, 1'b0, 32'h55, 4'd2, 1'b1, 1'b1, 32'h44, 32'd3};

      for (int v = 0; v < 10; v++) begin
         rst = vec[v].rst; src_valid = vec[v].valid;
         flagb = vec[v].flagb; src_data = vec[v].data;
         cycle();
         check("tbl_state", usb_wr_state, vec[v].e_state);
         check("tbl_slwr",  slwr_n,       vec[v].e_slwr_n);
         check("tbl_ready", src_ready,    vec[v].e_ready);
         check("tbl_oe",    dq_oe,        vec[v].e_state != 4'd0);
         check("tbl_dq",    dq_out,       vec[v].e_dq);
         check("tbl_ws",    words_sent,   vec[v].e_ws);
         check("tbl_pkend", pktend_n,     1'b1);
      end
      // Finish that burst with a continuous source: 253 more words.
      src_valid = 1'b1; flagb = 1'b1;
      for (int i = 0; i < 400 && (m_state != 0); i++) begin
         src_data = $urandom();
         cycle();
      end
      src_valid = 1'b0;
      check("tbl_burst_total", words_sent, 32'd256);
      check("tbl_burst_idle", usb_wr_state, 4'd0);

      // ---- reset values ----
      do_reset();
      check("rst_slwr",   slwr_n,       1'b1);
      check("rst_pktend", pktend_n,     1'b1);
      check("rst_oe",     dq_oe,        1'b0);
      check("rst_state",  usb_wr_state, 4'd0);
      check("rst_ws",     words_sent,   32'd0);

      // ---- full burst, continuous source ----
      pulses = 0; run = 0; max_run = 0; guard_cycles = 0; done = 1'b0;
      src_valid = 1'b1; flagb = 1'b1; src_data = 32'hAAAAAAAA;
      for (int i = 0; i < 400 && !done; i++) begin
         cycle();
         if (slwr_n === 1'b0) begin
            pulses++; run++;
            if (run > max_run) max_run = run;
            check("full_dq", dq_out, 32'hAAAAAAAA);
         end else run = 0;
         if (usb_wr_state == 4'd3) guard_cycles++;
         if ((guard_cycles > 0) && (usb_wr_state == 4'd0)) done = 1'b1;
      end
      src_valid = 1'b0;
      check("full_done",   done,         1'b1);
      check("full_pulses", pulses,       256);
      check("full_run",    max_run,      256);
      check("full_ws",     words_sent,   32'd256);
      check("full_guard",  guard_cycles, FD);

      // ---- FLAGB gate ----
      do_reset();
      src_valid = 1'b1; flagb = 1'b0; src_data = 32'h1234;
      cycle();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if ((usb_wr_state != 4'd1) || (slwr_n !== 1'b1)) bad++;
      end
      check("gate_hold", bad, 0);
      check("gate_pulses", pulse_cnt, 0);
      flagb = 1'b1;
      cycle();
      check("gate_open_state", usb_wr_state, 4'd2);
      check("gate_open_ready", src_ready, 1'b1);
      cycle();
      check("gate_first_strobe", slwr_n, 1'b0);
      flagb = 1'b0;  // a drop inside the burst must be ignored
      run_until_idle("gate_drain", 800);
      check("gate_total", words_sent, 32'd256);

      // ---- gapped source, data = word index ----
      do_reset();
      flagb = 1'b1; nxt = 0; seq_exp = 0; bad = 0; done = 1'b0; guard_cycles = 0;
      for (int i = 0; i < 900 && !done; i++) begin
         src_valid = i[0];
         src_data  = nxt;
         take      = src_valid && m_ready();
         cycle();
         if (take) nxt = nxt + 1;
         if (slwr_n === 1'b0) begin
            if (dq_out !== seq_exp) bad++;
            seq_exp = seq_exp + 1;
         end
         if (usb_wr_state == 4'd3) guard_cycles++;
         if ((guard_cycles > 0) && (usb_wr_state == 4'd0)) done = 1'b1;
      end
      src_valid = 1'b0;
      check("gap_done",    done,      1'b1);
      check("gap_pulses",  pulse_cnt, 256);
      check("gap_order",   bad,       0);
      check("gap_last",    dq_out,    32'd255);

      // ---- short packet ----
      do_reset();
      flagb = 1'b1; src_valid = 1'b1;
      for (int i = 0; i < 300 && (m_sent < 100); i++) begin
         src_data = $urandom();
         cycle();
      end
      src_valid = 1'b0;
      pk = 0; pk_at = -1;
`ifdef USB3_WR_PKTEND_EN
      for (int i = 0; i < PT + 20; i++) begin
         cycle();
         if (pktend_n === 1'b0) begin pk++; pk_at = i; end
      end
      check("short_pktend", pk, 1);
      check("short_pk_at",  pk_at, PT - 1);
      check("short_ws",     words_sent, 32'd100);
      check("short_idle",   usb_wr_state, 4'd0);
`else
      for (int i = 0; i < PT + 36; i++) begin
         cycle();
         if (pktend_n === 1'b0) pk++;
      end
      check("nopk_pulses", pk, 0);
      check("nopk_state",  usb_wr_state, 4'd2);
      check("nopk_ws",     words_sent, 32'd100);
`endif

      // ---- reset mid-burst at word 50 ----
      do_reset();
      flagb = 1'b1; src_valid = 1'b1;
      for (int i = 0; i < 300 && (m_sent < 50); i++) begin
         src_data = $urandom();
         cycle();
      end
      check("mid_ws50", words_sent, 32'd50);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("mid_slwr",  slwr_n,       1'b1);
      check("mid_state", usb_wr_state, 4'd0);
      check("mid_ws",    words_sent,   32'd0);
      pulse_cnt = 0;
      src_valid = 1'b1;
      cycle();
      run_until_idle("mid_fresh_done", 900);
      check("mid_fresh_pulses", pulse_cnt, 256);
      check("mid_fresh_ws", words_sent, 32'd256);

      // ---- randomized traffic ----
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         src_valid = ($urandom_range(0, 99) < 70);
         flagb     = ($urandom_range(0, 99) < 60);
         src_data  = $urandom();
         rst       = ($urandom_range(0, 999) == 0);
         cycle();
      end
      rst = 1'b0;
      // Long source gaps so partial bursts sit idle for a while.
      begin
         int hold;
         hold = 0;
         for (int i = 0; i < 2500; i++) begin
            if (hold == 0) begin
               src_valid = ($urandom_range(0, 1) == 1);
               hold = $urandom_range(1, 90);
            end
            hold--;
            flagb    = ($urandom_range(0, 99) < 50);
            src_data = $urandom();
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
